// File: rtl/ber_uart_reporter.sv
// ber_uart_reporter: serialises PRBS BER count snapshots as 10-byte UART frames.
// Frame: SYNC, total[31:0] MSB first, errors[31:0] MSB first, XOR checksum.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   send_data      snapshot-valid strobe, sampled every rising edge
//   error_bits_in  error count snapshot (valid with send_data)
//   total_bits_in  total bit count snapshot (valid with send_data)
//   tx             UART 8N1 serial output, idle high
//   busy           high while a frame is in flight
//   frame_done     one-cycle pulse after the last stop bit of a frame
//   drop_count     pending snapshots overwritten, saturating at 255
module ber_uart_reporter #(
    parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_data,
    input  logic [31:0] error_bits_in,
    input  logic [31:0] total_bits_in,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_count
);

    localparam int unsigned CNT_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BYTE = 4'd9;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Byte 0 sits in the low bits so each finished byte is shifted out
    // and the current byte is always frame_q[7:0].
    function automatic logic [79:0] build_frame(
        input logic [31:0] total,
        input logic [31:0] errs
    );
        logic [7:0] chk;
        chk = total[31:24] ^ total[23:16] ^ total[15:8] ^ total[7:0]
            ^ errs[31:24]  ^ errs[23:16]  ^ errs[15:8]  ^ errs[7:0];
        build_frame = {chk,
                       errs[7:0],   errs[15:8],
                       errs[23:16], errs[31:24],
                       total[7:0],  total[15:8],
                       total[23:16], total[31:24],
                       SYNC_BYTE};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       byte_idx_q, byte_idx_d;
    logic [79:0]      frame_q, frame_d;
    logic [31:0]      pend_total_q, pend_total_d;
    logic [31:0]      pend_err_q, pend_err_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       drop_q, drop_d;
    logic             done_q, done_d;

    logic        tick;
    logic        last_stop;
    logic        can_load;
    logic        take_new;
    logic        take_pend;
    logic        drop_inc;
    logic [31:0] load_total;
    logic [31:0] load_err;
    logic [7:0]  cur_byte;

    assign tick      = (cnt_q == CNT_MAX);
    assign last_stop = (state_q == S_STOP) && tick
                     && (byte_idx_q == LAST_BYTE);
    // A frame may load from IDLE or in the very cycle the previous one ends.
    assign can_load  = (state_q == S_IDLE) || last_stop;
    // A live sample beats whatever is waiting in the pending buffer.
    assign take_new  = can_load && send_data;
    assign take_pend = can_load && !send_data && pend_valid_q;

    assign load_total = send_data ? total_bits_in : pend_total_q;
    assign load_err   = send_data ? error_bits_in : pend_err_q;
    assign cur_byte   = frame_q[7:0];

    // Pending buffer and drop accounting.
    always_comb begin
        pend_total_d = pend_total_q;
        pend_err_d   = pend_err_q;
        pend_valid_d = pend_valid_q;
        drop_inc     = 1'b0;
        if (send_data && !can_load) begin
            pend_total_d = total_bits_in;
            pend_err_d   = error_bits_in;
            pend_valid_d = 1'b1;
            drop_inc     = pend_valid_q;
        end else if (take_new) begin
            pend_valid_d = 1'b0;
            drop_inc     = pend_valid_q;
        end else if (take_pend) begin
            pend_valid_d = 1'b0;
        end
        drop_d = drop_q;
        if (drop_inc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Frame sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take_new || take_pend) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    frame_d    = build_frame(load_total, load_err);
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (byte_idx_q != LAST_BYTE) begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 4'd1;
                        frame_d    = {8'h00, frame_q[79:8]};
                    end else begin
                        done_d = 1'b1;
                        if (take_new || take_pend) begin
                            // Back-to-back: no idle bit between frames.
                            state_d    = S_START;
                            bit_idx_d  = '0;
                            byte_idx_d = '0;
                            frame_d    = build_frame(load_total, load_err);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            frame_q      <= '0;
            pend_total_q <= '0;
            pend_err_q   <= '0;
            pend_valid_q <= 1'b0;
            drop_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            frame_q      <= frame_d;
            pend_total_q <= pend_total_d;
            pend_err_q   <= pend_err_d;
            pend_valid_q <= pend_valid_d;
            drop_q       <= drop_d;
            done_q       <= done_d;
        end
    end

    // Line level decodes straight from registered state, so tx drops
    // on the same edge that accepts a snapshot in IDLE.
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            S_IDLE:  tx = 1'b1;
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_idx_q];
            S_STOP:  tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_ber_uart_reporter.sv
// Bench for ber_uart_reporter: directed frame vectors plus random snapshots
// checked every cycle against a timing-level reference model.
module tb_ber_uart_reporter;

    localparam int CPB   = 4;
    localparam int FRAME = 100 * CPB;

    logic        clk;
    logic        rst;
    logic        send_data;
    logic [31:0] error_bits_in;
    logic [31:0] total_bits_in;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_count;

    ber_uart_reporter #(
        .CLK_FREQ_HZ(1000),
        .BAUD(250),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .send_data(send_data),
        .error_bits_in(error_bits_in),
        .total_bits_in(total_bits_in),
        .tx(tx),
        .busy(busy),
        .frame_done(frame_done),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] e;
        logic [79:0] f;
    } vec_t;

    vec_t vt [8];

    int n_cmp;
    int n_bad;
    int cyc;

    // Reference model: frame timing by absolute cycle number.
    bit          m_busy;
    bit          m_pv;
    bit          m_done;
    int          m_start;
    int          m_end;
    int          m_drops;
    logic [31:0] m_pt;
    logic [31:0] m_pe;
    logic [79:0] m_frame;

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [79:0] mk_frame(logic [31:0] t,
                                             logic [31:0] e);
        logic [7:0]  b [10];
        logic [79:0] r;
        b[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            b[1+i] = t[8*(3-i) +: 8];
            b[5+i] = e[8*(3-i) +: 8];
        end
        b[9] = 8'h00;
        for (int i = 1; i < 9; i++) b[9] = b[9] ^ b[i];
        r = '0;
        for (int i = 0; i < 10; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic logic exp_tx_at(int t, logic [79:0] f);
        int bn;
        int by;
        int pos;
        bn  = t / CPB;
        by  = bn / 10;
        pos = bn % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return f[by*8 + pos - 1];
    endfunction

    task automatic model_clear();
        m_busy  = 1'b0;
        m_pv    = 1'b0;
        m_done  = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_start(logic [31:0] t, logic [31:0] e);
        m_busy  = 1'b1;
        m_start = cyc;
        m_end   = cyc + FRAME;
        m_frame = mk_frame(t, e);
    endtask

    task automatic model_edge();
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            model_clear();
        end else if (m_busy && cyc == m_end) begin
            m_done = 1'b1;
            if (send_data) begin
                if (m_pv) m_drops++;
                m_pv = 1'b0;
                model_start(total_bits_in, error_bits_in);
            end else if (m_pv) begin
                m_pv = 1'b0;
                model_start(m_pt, m_pe);
            end else begin
                m_busy = 1'b0;
            end
        end else if (!m_busy) begin
            if (send_data) model_start(total_bits_in, error_bits_in);
        end else if (send_data) begin
            if (m_pv) m_drops++;
            m_pv = 1'b1;
            m_pt = total_bits_in;
            m_pe = error_bits_in;
        end
    endtask

    task automatic check_outputs();
        logic et;
        int   sat;
        et  = m_busy ? exp_tx_at(cyc - m_start, m_frame) : 1'b1;
        sat = (m_drops > 255) ? 255 : m_drops;
        chk("tx", 80'(tx), 80'(et));
        chk("busy", 80'(busy), 80'(m_busy));
        chk("frame_done", 80'(frame_done), 80'(m_done));
        chk("drop_count", 80'(drop_count), 80'(sat));
    endtask

    // Called at a negedge: drive, take one edge, check at next negedge.
    task automatic cycle(input bit sd, input logic [31:0] t,
                         input logic [31:0] e);
        send_data     = sd;
        total_bits_in = t;
        error_bits_in = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Entered with t=0 of a frame visible; decodes it over 400 cycles.
    // Pulses: np snapshots (pt+k, pe+k) at j = p_at + 20k.
    task automatic grab(input int p_at, input int np,
                        input logic [31:0] pt, input logic [31:0] pe,
                        input bit tim, input logic [79:0] exp,
                        input string nm);
        logic [99:0] bits;
        logic [79:0] got;
        logic [31:0] ct;
        logic [31:0] ce;
        logic [9:0]  pat;
        bit          sd;
        int          nd;
        int          k;
        pat  = 10'b11_0100_1010;
        ct   = total_bits_in;
        ce   = error_bits_in;
        nd   = 0;
        bits = '0;
        for (int j = 0; j < FRAME; j++) begin
            if (j % CPB == CPB / 2) bits[j/CPB] = tx;
            if (j > 0 && frame_done) nd++;
            if (tim && j < 10 * CPB)
                chk("bit_timing", 80'(tx), 80'(pat[j/CPB]));
            sd = 1'b0;
            if (np > 0 && j >= p_at && (j - p_at) % 20 == 0) begin
                k = (j - p_at) / 20;
                if (k < np) begin
                    sd = 1'b1;
                    ct = pt + 32'(k);
                    ce = pe + 32'(k);
                end
            end
            cycle(sd, ct, ce);
        end
        got = '0;
        for (int b = 0; b < 10; b++)
            for (int i = 0; i < 8; i++)
                got[72 - 8*b + i] = bits[b*10 + 1 + i];
        chk({nm, "_bytes"}, got, exp);
        chk({nm, "_done_mid"}, 80'(nd), 80'(0));
    endtask

    initial begin
        int dens;
        bit sd;

        vt[0] = '{32'h64, 32'h3, 80'hA5_00000064_00000003_67};
        vt[1] = '{32'h1, 32'h0, 80'hA5_00000001_00000000_01};
        vt[2] = '{32'h2, 32'h1, 80'hA5_00000002_00000001_03};
        vt[3] = '{32'hDEADBEEF, 32'h12345678,
                  80'hA5_DEADBEEF_12345678_2A};
        vt[4] = '{32'hFFFFFFFF, 32'h0, 80'hA5_FFFFFFFF_00000000_00};
        vt[5] = '{32'h12, 32'h22, 80'hA5_00000012_00000022_30};
        vt[6] = '{32'h57, 32'h61, 80'hA5_00000057_00000061_36};
        vt[7] = '{32'h80000001, 32'h00FF00FF,
                  80'hA5_80000001_00FF00FF_81};

        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        model_clear();
        rst           = 1'b1;
        send_data     = 1'b0;
        total_bits_in = '0;
        error_bits_in = '0;

        @(negedge clk);
        repeat (3) cycle(1'b0, '0, '0);
        rst = 1'b0;
        chk("rst_tx", 80'(tx), 80'(1));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_done", 80'(frame_done), 80'(0));
        chk("rst_drop", 80'(drop_count), 80'(0));
        repeat (2) cycle(1'b0, '0, '0);

        // Single frames from the vector table.
        for (int v = 0; v < 8; v += 1) begin
            if (v == 0 || v == 3 || v == 4 || v == 7) begin
                chk("pre_tx", 80'(tx), 80'(1));
                cycle(1'b1, vt[v].t, vt[v].e);
                chk("lat_tx", 80'(tx), 80'(0));
                chk("lat_busy", 80'(busy), 80'(1));
                grab(-1, 0, '0, '0, (v == 0), vt[v].f, "single");
                chk("end_done", 80'(frame_done), 80'(1));
                chk("end_busy", 80'(busy), 80'(0));
                chk("end_tx", 80'(tx), 80'(1));
                cycle(1'b0, vt[v].t, vt[v].e);
                chk("done_once", 80'(frame_done), 80'(0));
                repeat (3) cycle(1'b0, '0, '0);
            end
        end

        // Snapshot isolation and one pending frame.
        cycle(1'b1, vt[1].t, vt[1].e);
        grab(100, 1, vt[2].t, vt[2].e, 1'b0, vt[1].f, "iso1");
        chk("iso_gap_done", 80'(frame_done), 80'(1));
        chk("iso_gap_busy", 80'(busy), 80'(1));
        chk("iso_gap_tx", 80'(tx), 80'(0));
        grab(-1, 0, '0, '0, 1'b0, vt[2].f, "iso2");
        chk("iso_end_busy", 80'(busy), 80'(0));
        chk("iso_drop", 80'(drop_count), 80'(0));
        repeat (3) cycle(1'b0, '0, '0);

        // Three pulses in one frame: two overwrites.
        cycle(1'b1, vt[4].t, vt[4].e);
        grab(50, 3, 32'h10, 32'h20, 1'b0, vt[4].f, "ovr1");
        grab(-1, 0, '0, '0, 1'b0, vt[5].f, "ovr2");
        chk("ovr_drop", 80'(drop_count), 80'(2));
        repeat (3) cycle(1'b0, '0, '0);

        // Pending set, then send_data on the last stop-bit cycle.
        cycle(1'b1, vt[0].t, vt[0].e);
        grab(379, 2, 32'h56, 32'h60, 1'b0, vt[0].f, "coin1");
        chk("coin_done", 80'(frame_done), 80'(1));
        chk("coin_busy", 80'(busy), 80'(1));
        chk("coin_drop", 80'(drop_count), 80'(3));
        grab(-1, 0, '0, '0, 1'b0, vt[6].f, "coin2");
        chk("coin_end_busy", 80'(busy), 80'(0));
        chk("coin_end_drop", 80'(drop_count), 80'(3));

        // Saturation: a snapshot every other cycle.
        for (int i = 0; i < 800; i++)
            cycle((i % 2) == 0, 32'(i), ~32'(i));
        chk("sat_drop", 80'(drop_count), 80'(255));
        for (int i = 0; i < 2000 && busy; i++) cycle(1'b0, '0, '0);
        chk("sat_drain", 80'(busy), 80'(0));
        chk("sat_hold", 80'(drop_count), 80'(255));

        // Async reset during byte 4.
        cycle(1'b1, vt[3].t, vt[3].e);
        repeat (170) cycle(1'b0, vt[3].t, vt[3].e);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", 80'(tx), 80'(1));
        chk("arst_busy", 80'(busy), 80'(0));
        chk("arst_drop", 80'(drop_count), 80'(0));
        model_clear();
        @(negedge clk);
        repeat (2) cycle(1'b0, '0, '0);
        rst = 1'b0;
        repeat (20) cycle(1'b0, '0, '0);
        chk("arst_idle", 80'(busy), 80'(0));
        cycle(1'b1, vt[7].t, vt[7].e);
        grab(-1, 0, '0, '0, 1'b0, vt[7].f, "arst_frame");
        chk("arst_after_drop", 80'(drop_count), 80'(0));

        // Random snapshots at varying densities.
        for (int s = 0; s < 10; s++) begin
            dens = 20 + s * 60;
            for (int i = 0; i < 2000; i++) begin
                sd = ($urandom_range(0, dens - 1) == 0);
                cycle(sd, $urandom, $urandom);
            end
        end
        for (int i = 0; i < 2000 && busy; i++) cycle(1'b0, '0, '0);
        chk("final_idle", 80'(busy), 80'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
